// File: rtl/reg_bank_pkg.sv
// Shared definitions for the datapath register bank: default widths,
// bulk-clear FSM states and the write-port precedence rule.
package reg_bank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // Bulk-clear engine states.
  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // When both write ports hit one address in a cycle, the load port (w1)
  // commits and the ALU port (w0) is dropped.
  localparam logic LOAD_PORT_WINS = 1'b1;

endpackage

// File: rtl/reg_bank_fwd.sv
// Combinational forwarding mux for one read port. It produces the value
// and pending bit the addressed register will hold after this edge, so a
// write in the same cycle reaches the registered output without a bubble.
module reg_bank_fwd #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_pend,
  input  logic              w0_commit,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_commit,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              rsv_commit,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_pend
);

  // Later assignments override earlier ones: w1 over w0, reservation over
  // write-clear, and a hard-wired zero register over everything.
  always_comb begin
    fwd_data = arr_data;
    fwd_pend = arr_pend;
    if (w0_commit && (w0_addr == rd_addr)) begin
      fwd_data = w0_data;
      fwd_pend = 1'b0;
    end
    if (w1_commit && (w1_addr == rd_addr)) begin
      fwd_data = w1_data;
      fwd_pend = 1'b0;
    end
    if (rsv_commit && (rsv_addr == rd_addr)) begin
      fwd_pend = 1'b1;
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      fwd_data = '0;
      fwd_pend = 1'b0;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Multi-port datapath register bank: two registered read ports with
// same-cycle write forwarding, ALU and load write ports, a per-register
// pending scoreboard and a sequential bulk-clear engine.
//
// Handshake note: there is no valid/ready flow control here. Write and
// reservation enables are single-cycle qualifiers acted on at the edge
// they are sampled, except while clr_busy is high, when they are dropped.
// clr_req is a level sampled only in IDLE; clr_done is a one-cycle pulse.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              w0_en,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              clr_done_q, clr_done_d;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;

  logic busy;
  logic w0_ok, w1_ok, rsv_ok, same_addr;
  logic w0_commit, w1_commit;

  // Qualify write/reservation requests: blocked during clear, dropped on a
  // hard-wired zero register, and w0/w1 collisions resolved by precedence.
  always_comb begin
    busy      = (state_q == CLR_CLEAR);
    w0_ok     = w0_en  && !busy && !((ZERO_REG != 0) && (w0_addr  == '0));
    w1_ok     = w1_en  && !busy && !((ZERO_REG != 0) && (w1_addr  == '0));
    rsv_ok    = rsv_en && !busy && !((ZERO_REG != 0) && (rsv_addr == '0));
    same_addr = (w0_addr == w1_addr);
    w0_commit = w0_ok && !(LOAD_PORT_WINS  && w1_ok && same_addr);
    w1_commit = w1_ok && !(!LOAD_PORT_WINS && w0_ok && same_addr);
  end

  // Next state of the array and scoreboard: one register cleared per cycle
  // while busy, otherwise committed writes land and reservations win.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (busy) begin
      regs_d[clr_idx_q] = '0;
      pend_d[clr_idx_q] = 1'b0;
    end else begin
      if (w0_commit) begin
        regs_d[w0_addr] = w0_data;
        pend_d[w0_addr] = 1'b0;
      end
      if (w1_commit) begin
        regs_d[w1_addr] = w1_data;
        pend_d[w1_addr] = 1'b0;
      end
      if (rsv_ok) begin
        pend_d[rsv_addr] = 1'b1;
      end
    end
  end

  reg_bank_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .rd_addr    (a_addr),
    .arr_data   (regs_q[a_addr]),
    .arr_pend   (pend_q[a_addr]),
    .w0_commit  (w0_commit),
    .w0_addr    (w0_addr),
    .w0_data    (w0_data),
    .w1_commit  (w1_commit),
    .w1_addr    (w1_addr),
    .w1_data    (w1_data),
    .rsv_commit (rsv_ok),
    .rsv_addr   (rsv_addr),
    .fwd_data   (data_a_d),
    .fwd_pend   (pend_a_d)
  );

  reg_bank_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .rd_addr    (b_addr),
    .arr_data   (regs_q[b_addr]),
    .arr_pend   (pend_q[b_addr]),
    .w0_commit  (w0_commit),
    .w0_addr    (w0_addr),
    .w0_data    (w0_data),
    .w1_commit  (w1_commit),
    .w1_addr    (w1_addr),
    .w1_data    (w1_data),
    .rsv_commit (rsv_ok),
    .rsv_addr   (rsv_addr),
    .fwd_data   (data_b_d),
    .fwd_pend   (pend_b_d)
  );

  // Clear FSM next state: walk every index once, pulse done on exit.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clr_done_d = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d   = CLR_CLEAR;
          clr_idx_d = '0;
        end
      end
      CLR_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d    = CLR_IDLE;
          clr_idx_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = CLR_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLR_IDLE;
      clr_idx_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Register array, scoreboard and registered read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  assign data_a   = data_a_q;
  assign data_b   = data_b_q;
  assign pend_a   = pend_a_q;
  assign pend_b   = pend_b_q;
  assign clr_busy = busy;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank. Two instances (ZERO_REG=0 and 1) share
// one stimulus stream and are compared against a behavioural model of the
// register file, scoreboard and clear sequence.
module tb_reg_bank;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr, b_addr, w0_addr, w1_addr, rsv_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic          w0_en, w1_en, rsv_en, clr_req;

  logic [DW-1:0] da0, db0, da1, db1;
  logic          pa0, pb0, pa1, pb1, busy0, busy1, done0, done1;
  logic [DW-1:0] da [2];
  logic [DW-1:0] db [2];
  logic          pa [2];
  logic          pb [2];
  logic          busy [2];
  logic          done [2];

  assign da[0] = da0;  assign da[1] = da1;
  assign db[0] = db0;  assign db[1] = db1;
  assign pa[0] = pa0;  assign pa[1] = pa1;
  assign pb[0] = pb0;  assign pb[1] = pb1;
  assign busy[0] = busy0;  assign busy[1] = busy1;
  assign done[0] = done0;  assign done[1] = done1;

  reg_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .a_addr(a_addr), .b_addr(b_addr),
    .data_a(da0), .data_b(db0), .pend_a(pa0), .pend_b(pb0),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
    .clr_busy(busy0), .clr_done(done0)
  );

  reg_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .a_addr(a_addr), .b_addr(b_addr),
    .data_a(da1), .data_b(db1), .pend_a(pa1), .pend_b(pb1),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
    .clr_busy(busy1), .clr_done(done1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 = ZERO_REG=0 instance, 1 = ZERO_REG=1 instance
  logic [DW-1:0] m_regs [2][DEPTH];
  logic          m_pend [2][DEPTH];
  bit            m_busy;
  int            m_idx;
  logic [DW-1:0] e_da [2];
  logic [DW-1:0] e_db [2];
  logic          e_pa [2];
  logic          e_pb [2];
  logic          e_busy, e_done;
  bit            e_rd_valid;

  function automatic bit dropped(int z, logic [AW-1:0] a);
    return (z == 1) && (a == 0);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[z][i] = '0;
        m_pend[z][i] = 1'b0;
      end
      e_da[z] = '0; e_db[z] = '0; e_pa[z] = 1'b0; e_pb[z] = 1'b0;
    end
    m_busy = 0; m_idx = 0; e_busy = 1'b0; e_done = 1'b0; e_rd_valid = 1;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [DW-1:0] nr [DEPTH];
    logic          np [DEPTH];
    e_rd_valid = !m_busy;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < DEPTH; i++) begin
        nr[i] = m_regs[z][i];
        np[i] = m_pend[z][i];
      end
      if (m_busy) begin
        nr[m_idx] = '0;
        np[m_idx] = 1'b0;
      end else begin
        if (w0_en && !dropped(z, w0_addr)) begin nr[w0_addr] = w0_data; np[w0_addr] = 1'b0; end
        if (w1_en && !dropped(z, w1_addr)) begin nr[w1_addr] = w1_data; np[w1_addr] = 1'b0; end
        if (rsv_en && !dropped(z, rsv_addr)) np[rsv_addr] = 1'b1;
      end
      e_da[z] = nr[a_addr]; e_pa[z] = np[a_addr];
      e_db[z] = nr[b_addr]; e_pb[z] = np[b_addr];
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[z][i] = nr[i];
        m_pend[z][i] = np[i];
      end
    end
    e_done = m_busy && (m_idx == DEPTH - 1);
    if (m_busy) begin
      if (m_idx == DEPTH - 1) begin m_busy = 0; m_idx = 0; end
      else m_idx++;
    end else if (clr_req) begin
      m_busy = 1; m_idx = 0;
    end
    e_busy = m_busy;
  endtask

  // Driver tasks
  task automatic idle_inputs();
    w0_en = 0; w1_en = 0; rsv_en = 0; clr_req = 0;
    w0_addr = '0; w1_addr = '0; rsv_addr = '0; w0_data = '0; w1_data = '0;
    a_addr = '0; b_addr = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    for (int z = 0; z < 2; z++) begin
      checks++; if (da[z] !== 8'h00) begin failures++; $display("FAIL reset_data_a[%0d] got=%0h exp=0", z, da[z]); end
      checks++; if (db[z] !== 8'h00) begin failures++; $display("FAIL reset_data_b[%0d] got=%0h exp=0", z, db[z]); end
      checks++; if (pa[z] !== 1'b0) begin failures++; $display("FAIL reset_pend_a[%0d] got=%0b exp=0", z, pa[z]); end
      checks++; if (pb[z] !== 1'b0) begin failures++; $display("FAIL reset_pend_b[%0d] got=%0b exp=0", z, pb[z]); end
      checks++; if (busy[z] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%0b exp=0", z, busy[z]); end
      checks++; if (done[z] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] got=%0b exp=0", z, done[z]); end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    idle_inputs();
    w0_en = 1; w0_addr = 3; w0_data = 8'h5A; a_addr = 3;
    tick();
    checks++; if (da[0] !== 8'h5A) begin failures++; $display("FAIL wr_fwd_a got=%0h exp=5a", da[0]); end
    idle_inputs(); a_addr = 3;
    tick();
    checks++; if (da[0] !== 8'h5A) begin failures++; $display("FAIL wr_read_a got=%0h exp=5a", da[0]); end
    checks++; if (da[1] !== 8'h5A) begin failures++; $display("FAIL wr_read_a_z got=%0h exp=5a", da[1]); end
    checks++; if (pa[0] !== 1'b0) begin failures++; $display("FAIL wr_read_pend got=%0b exp=0", pa[0]); end
  endtask

  task automatic test_precedence();
    idle_inputs();
    w0_en = 1; w0_addr = 4; w0_data = 8'h11;
    w1_en = 1; w1_addr = 4; w1_data = 8'h22; a_addr = 4;
    tick();
    checks++; if (da[0] !== 8'h22) begin failures++; $display("FAIL prec_fwd got=%0h exp=22", da[0]); end
    idle_inputs(); a_addr = 4; b_addr = 4;
    tick();
    checks++; if (da[0] !== 8'h22) begin failures++; $display("FAIL prec_hold_a got=%0h exp=22", da[0]); end
    checks++; if (db[1] !== 8'h22) begin failures++; $display("FAIL prec_hold_b got=%0h exp=22", db[1]); end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    rsv_en = 1; rsv_addr = 2; b_addr = 2;
    tick();
    checks++; if (pb[0] !== 1'b1) begin failures++; $display("FAIL sb_rsv got=%0b exp=1", pb[0]); end
    idle_inputs();
    w1_en = 1; w1_addr = 2; w1_data = 8'h7F; b_addr = 2;
    tick();
    checks++; if (pb[0] !== 1'b0) begin failures++; $display("FAIL sb_wr_clear got=%0b exp=0", pb[0]); end
    checks++; if (db[0] !== 8'h7F) begin failures++; $display("FAIL sb_wr_data got=%0h exp=7f", db[0]); end
    idle_inputs();
    rsv_en = 1; rsv_addr = 2; w0_en = 1; w0_addr = 2; w0_data = 8'h33; b_addr = 2;
    tick();
    checks++; if (pb[0] !== 1'b1) begin failures++; $display("FAIL sb_rsv_wins got=%0b exp=1", pb[0]); end
    checks++; if (db[0] !== 8'h33) begin failures++; $display("FAIL sb_rsv_data got=%0h exp=33", db[0]); end
    idle_inputs(); b_addr = 2;
    tick();
    checks++; if (pb[1] !== 1'b1 || db[1] !== 8'h33) begin
      failures++; $display("FAIL sb_hold got=%0b/%0h exp=1/33", pb[1], db[1]);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    w0_en = 1; w0_addr = 0; w0_data = 8'hFF; rsv_en = 1; rsv_addr = 0; a_addr = 0;
    tick();
    checks++; if (da[1] !== 8'h00 || pa[1] !== 1'b0) begin
      failures++; $display("FAIL zero_fwd got=%0h/%0b exp=0/0", da[1], pa[1]);
    end
    checks++; if (da[0] !== 8'hFF || pa[0] !== 1'b1) begin
      failures++; $display("FAIL nonzero_r0 got=%0h/%0b exp=ff/1", da[0], pa[0]);
    end
    idle_inputs(); a_addr = 0;
    tick();
    checks++; if (da[1] !== 8'h00 || pa[1] !== 1'b0) begin
      failures++; $display("FAIL zero_hold got=%0h/%0b exp=0/0", da[1], pa[1]);
    end
  endtask

  task automatic test_clear();
    int busy_cnt [2];
    int done_cnt [2];
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      w0_en = 1; w0_addr = AW'(i); w0_data = DW'($urandom_range(1, 255));
      rsv_en = 1; rsv_addr = AW'(DEPTH - 1 - i);
      tick();
    end
    busy_cnt[0] = 0; busy_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      clr_req = (k < 5);
      if (k <= 8) begin
        w0_en = 1; w0_addr = AW'($urandom_range(0, 7)); w0_data = DW'($urandom_range(1, 255));
        w1_en = 1; w1_addr = AW'($urandom_range(0, 7)); w1_data = DW'($urandom_range(1, 255));
        rsv_en = 1; rsv_addr = AW'($urandom_range(0, 7));
      end
      tick();
      for (int z = 0; z < 2; z++) begin
        if (busy[z] === 1'b1) busy_cnt[z]++;
        if (done[z] === 1'b1) done_cnt[z]++;
        checks++; if (busy[z] !== e_busy || done[z] !== e_done) begin
          failures++; $display("FAIL clr_flags[%0d] k=%0d got=%0b/%0b exp=%0b/%0b", z, k, busy[z], done[z], e_busy, e_done);
        end
      end
    end
    for (int z = 0; z < 2; z++) begin
      checks++; if (busy_cnt[z] != DEPTH) begin failures++; $display("FAIL clr_busy_len[%0d] got=%0d exp=%0d", z, busy_cnt[z], DEPTH); end
      checks++; if (done_cnt[z] != 1) begin failures++; $display("FAIL clr_done_cnt[%0d] got=%0d exp=1", z, done_cnt[z]); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs(); a_addr = AW'(i); b_addr = AW'(DEPTH - 1 - i);
      tick();
      for (int z = 0; z < 2; z++) begin
        checks++; if (da[z] !== 8'h00 || pa[z] !== 1'b0 || db[z] !== 8'h00 || pb[z] !== 1'b0) begin
          failures++; $display("FAIL clr_zero[%0d] r%0d got=%0h/%0b %0h/%0b exp=0", z, i, da[z], pa[z], db[z], pb[z]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    int done_seen;
    bit saw_done;
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs(); w1_en = 1; w1_addr = AW'(i); w1_data = DW'($urandom_range(1, 255));
      tick();
    end
    idle_inputs(); clr_req = 1;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    for (int z = 0; z < 2; z++) begin
      checks++; if (busy[z] !== 1'b0 || done[z] !== 1'b0 || da[z] !== 8'h00 || db[z] !== 8'h00 ||
                    pa[z] !== 1'b0 || pb[z] !== 1'b0) begin
        failures++; $display("FAIL rst_mid_clear[%0d] got busy=%0b done=%0b a=%0h b=%0h exp=0", z, busy[z], done[z], da[z], db[z]);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); a_addr = AW'(k + 3); b_addr = AW'(k);
      tick();
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) saw_done = 1;
      checks++; if (da[0] !== 8'h00 || db[0] !== 8'h00) begin
        failures++; $display("FAIL rst_regs_zero got=%0h/%0h exp=0/0", da[0], db[0]);
      end
    end
    checks++; if (saw_done) begin failures++; $display("FAIL rst_no_done got=1 exp=0"); end
    idle_inputs(); clr_req = 1;
    tick();
    idle_inputs();
    busy_cnt = 1;
    done_seen = 0;
    for (int k = 0; k < 20 && done_seen == 0; k++) begin
      tick();
      if (busy[0] === 1'b1) busy_cnt++;
      if (done[0] === 1'b1) done_seen = k + 1;
    end
    checks++; if (done_seen == 0) begin failures++; $display("FAIL restart_timeout got=no_done exp=done"); end
    checks++; if (busy_cnt != DEPTH) begin failures++; $display("FAIL restart_len got=%0d exp=%0d", busy_cnt, DEPTH); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      a_addr = AW'($urandom_range(0, 7)); b_addr = AW'($urandom_range(0, 7));
      w0_en = ($urandom_range(0, 1) == 1); w0_addr = AW'($urandom_range(0, 7)); w0_data = DW'($urandom);
      w1_en = ($urandom_range(0, 1) == 1); w1_data = DW'($urandom);
      w1_addr = ($urandom_range(0, 3) == 0) ? w0_addr : AW'($urandom_range(0, 7));
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? w1_addr : AW'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 39) == 0);
      tick();
      for (int z = 0; z < 2; z++) begin
        checks++; if (busy[z] !== e_busy || done[z] !== e_done) begin
          failures++; $display("FAIL rnd_flags[%0d] n=%0d got=%0b/%0b exp=%0b/%0b", z, n, busy[z], done[z], e_busy, e_done);
        end
        if (e_rd_valid) begin
          checks++; if (da[z] !== e_da[z] || pa[z] !== e_pa[z]) begin
            failures++; $display("FAIL rnd_port_a[%0d] n=%0d got=%0h/%0b exp=%0h/%0b", z, n, da[z], pa[z], e_da[z], e_pa[z]);
          end
          checks++; if (db[z] !== e_db[z] || pb[z] !== e_pb[z]) begin
            failures++; $display("FAIL rnd_port_b[%0d] n=%0d got=%0h/%0b exp=%0h/%0b", z, n, db[z], pb[z], e_db[z], e_pb[z]);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_write_read();
    test_precedence();
    test_scoreboard();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
